// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/sub, LSB first, one bit per clock through one full adder.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ans,
   output logic             carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb, res_sh;
   logic             c_ff;
   logic [CW-1:0]    cnt;
   logic             s, cout, last;

   full_adder u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (c_ff),
      .s    (s),
      .cout (cout)
   );

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Subtract is A + ~B + 1: invert B on capture and seed the carry with mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         res_sh <= '0;
         c_ff   <= 1'b0;
         cnt    <= '0;
         ans    <= '0;
         carry  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sa     <= a;
               sb     <= (mode == MODE_SUB) ? ~b : b;
               c_ff   <= mode;
               res_sh <= '0;
               cnt    <= '0;
            end
            RUN: begin
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               c_ff   <= cout;
               res_sh <= {s, res_sh[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
               if (last) begin
                  ans   <= {s, res_sh[WIDTH-1:1]};
                  carry <= cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: driver pushes expectations, monitor checks each done.
module tb_serial_add_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, mode;
   logic [W-1:0] a, b;
   logic         busy, done, carry;
   logic [W-1:0] ans;

   serial_add_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
      .busy(busy), .done(done), .ans(ans), .carry(carry)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] ans;
      logic         carry;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   mon_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      logic [W-1:0] yy;
      yy = m ? ~y : y;
      return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, m};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops on every done, checks latency, pulse width, busy overlap, and output hold.
   logic         prev_done = 0, prev_busy = 0, prev_rst = 0, prev_carry = 0;
   logic [W-1:0] prev_ans = '0;
   int           run = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy) run = prev_busy ? run + 1 : 1;
         if (done) begin
            chk("done_not_busy", busy, 0);
            chk("done_one_cycle", prev_done, 0);
            chk("busy_len", run, W);
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("ans", ans, e.ans);
               chk("carry", carry, e.carry);
               chk("latency", cyc - e.acc, W);
            end
         end else if (!prev_rst) begin
            chk("ans_hold", {carry, ans}, {prev_carry, prev_ans});
         end
      end
      prev_done  = done;
      prev_busy  = busy;
      prev_rst   = rst;
      prev_ans   = ans;
      prev_carry = carry;
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy || done) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_idle: busy=%0b done=%0b required idle", busy, done);
      end
   endtask

   // Issue one op; caller supplies the expected result.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                        input logic [W-1:0] e_ans, input logic e_c);
      exp_t e;
      wait_idle();
      a = x; b = y; mode = m; start = 1'b1;
      e.ans = e_ans; e.carry = e_c; e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   logic [W-1:0] ra, rb;
   logic         rm;
   logic [W:0]   rr;
   exp_t         eb;

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ans", ans, 0);
      chk("rst_carry", carry, 0);
      rst = 1'b0;
      mon_en = 1;

      // Directed vectors, expected values computed by hand.
      do_op(8'd15,  8'd11,  1'b1, 8'd4,   1'b1);
      do_op(8'd111, 8'd41,  1'b0, 8'd152, 1'b0);
      do_op(8'd200, 8'd100, 1'b0, 8'd44,  1'b1);
      do_op(8'd3,   8'd5,   1'b1, 8'd254, 1'b0);
      do_op(8'd3,   8'd2,   1'b1, 8'd1,   1'b1);
      do_op(8'd255, 8'd255, 1'b0, 8'd254, 1'b1);
      do_op(8'd0,   8'd0,   1'b1, 8'd0,   1'b1);
      do_op(8'd0,   8'd1,   1'b1, 8'd255, 1'b0);
      drain();

      // start held high, operands scrambled every cycle; only IDLE-edge values matter.
      wait_idle();
      for (int k = 0; k < 3 * (W + 2); k++) begin
         start = 1'b1;
         if (k == 0)                begin a = 8'd10;  b = 8'd20; mode = 1'b0; end
         else if (k == W + 2)       begin a = 8'd50;  b = 8'd60; mode = 1'b1; end
         else if (k == 2 * (W + 2)) begin a = 8'd255; b = 8'd1;  mode = 1'b0; end
         else begin a = W'(k * 37); b = W'(k * 53); mode = k[0]; end
         if (k == 0)                begin eb.ans = 8'd30;  eb.carry = 1'b0; eb.acc = cyc + 1; q.push_back(eb); end
         if (k == W + 2)            begin eb.ans = 8'd246; eb.carry = 1'b0; eb.acc = cyc + 1; q.push_back(eb); end
         if (k == 2 * (W + 2))      begin eb.ans = 8'd0;   eb.carry = 1'b1; eb.acc = cyc + 1; q.push_back(eb); end
         @(posedge clk); #1;
      end
      start = 1'b0;
      drain();

      // Reset on the 4th RUN cycle discards the op and clears outputs.
      wait_idle();
      a = 8'd15; b = 8'd11; mode = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ans", ans, 0);
      chk("abort_carry", carry, 0);
      do_op(8'd9, 8'd9, 1'b1, 8'd0, 1'b1);
      drain();

      // start and rst on the same edge: reset wins.
      rst = 1'b1; start = 1'b1; a = 8'd1; b = 8'd1; mode = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", busy, 0);
      @(posedge clk); #1;
      chk("rst_start_busy2", busy, 0);

      // Random sweep against the arithmetic reference.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
         rr = model(ra, rb, rm);
         do_op(ra, rb, rm, rr[W-1:0], rr[W]);
      end
      drain();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
